// File: rtl/line_mem_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_engine_if
// Description : Bundle of the line-request / line-response handshake and the
//               word-wide data-memory opcode port used by line_mem_engine.
//               slave  : engine view (accepts requests, drives memory port)
//               master : L2 + data-memory view (issues requests, serves words)
// Ports       : req_valid/req_ready/req_write/req_line_addr/req_wdata,
//               resp_valid/resp_ready/resp_rdata,
//               opcode_out/addr_out/data_to_dmem/data_from_dmem
// Revision    : 1.0 - initial release
// ============================================================================
interface line_mem_engine_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_BITS      = 32 * WORDS_PER_LINE
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_line_addr;
    logic [LINE_BITS-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [LINE_BITS-1:0] resp_rdata;
    logic [6:0]           opcode_out;
    logic [31:0]          addr_out;
    logic [31:0]          data_to_dmem;
    logic [31:0]          data_from_dmem;

    modport slave (
        input  req_valid, req_write, req_line_addr, req_wdata,
        input  resp_ready, data_from_dmem,
        output req_ready, resp_valid, resp_rdata,
        output opcode_out, addr_out, data_to_dmem
    );

    modport master (
        output req_valid, req_write, req_line_addr, req_wdata,
        output resp_ready, data_from_dmem,
        input  req_ready, resp_valid, resp_rdata,
        input  opcode_out, addr_out, data_to_dmem
    );
endinterface
`default_nettype wire

// File: rtl/line_mem_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_engine
// Description : Cache-line transfer initiator. Accepts one line request from
//               L2 (refill or writeback), issues one load/store opcode per
//               cycle to the word-wide data memory in ascending address
//               order, gathers load data and returns the line on a
//               valid/ready response.
// Ports       : clk   - system clock, all state changes on posedge
//               reset - asynchronous active-low reset
//               bus   - line_mem_engine_if.slave (request, response and
//                       data-memory opcode port)
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_engine #(
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_BITS      = 32 * WORDS_PER_LINE
) (
    input  logic             clk,
    input  logic             reset,
    line_mem_engine_if.slave bus
);
    localparam int c_cnt_w = $clog2(WORDS_PER_LINE);
    localparam int c_off_w = c_cnt_w + 2;

    // Clears the byte/word offset so the base is line-aligned.
    localparam logic [31:0]        c_base_mask = ~((32'd1 << c_off_w) - 32'd1);
    localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(WORDS_PER_LINE - 1);

    localparam logic [6:0] c_op_idle  = 7'b0000000;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_xfer = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_write;
    logic [31:0]          r_base;
    logic [LINE_BITS-1:0] r_wdata;
    logic [31:0]          r_rdata_words [WORDS_PER_LINE];
    logic [31:0]          w_wdata_words [WORDS_PER_LINE];

    // Word views of the latched store line and the collected load line.
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
        assign w_wdata_words[gi]          = r_wdata[32*gi +: 32];
        assign bus.resp_rdata[32*gi +: 32] = r_rdata_words[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                r_rdata_words[i] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_base  <= bus.req_line_addr & c_base_mask;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= '0;
                        r_state <= c_st_xfer;
                    end
                end
                c_st_xfer: begin
                    // Memory returns load data combinationally within the
                    // cycle, so it is captured at the edge closing the cycle.
                    if (!r_write) begin
                        r_rdata_words[r_cnt] <= bus.data_from_dmem;
                    end
                    if (r_cnt == c_last_cnt) begin
                        r_cnt   <= '0;
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    if (bus.resp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // All outputs are decoded from registered state only, so they are stable
    // for the whole cycle including the negedge at which memory stores.
    always_comb begin
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.opcode_out   = c_op_idle;
        bus.addr_out     = '0;
        bus.data_to_dmem = '0;
        case (r_state)
            c_st_idle: bus.req_ready = 1'b1;
            c_st_xfer: begin
                bus.opcode_out   = r_write ? c_op_store : c_op_load;
                bus.addr_out     = r_base + (32'(r_cnt) << 2);
                bus.data_to_dmem = r_write ? w_wdata_words[r_cnt] : 32'd0;
            end
            c_st_resp: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_line_mem_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_engine
// Description : Scoreboard bench for line_mem_engine. A driver issues line
//               requests, a line-level reference model predicts the memory
//               operations and the response, and a monitor compares what the
//               engine presents against the queued predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_engine;
    localparam int WPL = 4;
    localparam int LB  = 32 * WPL;
    localparam logic [6:0] c_load  = 7'b0000011;
    localparam logic [6:0] c_store = 7'b0100011;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } op_t;

    typedef struct {
        logic [LB-1:0] rdata;
        int            e0;
    } resp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   rr_delay;
    int   vcnt;
    int   done_cyc;

    op_t   op_q[$];
    resp_t resp_q[$];

    logic [31:0]   mem     [256];
    logic [31:0]   ref_mem [256];
    logic [LB-1:0] last_rdata;

    line_mem_engine_if #(.WORDS_PER_LINE(WPL)) bus ();

    line_mem_engine #(.WORDS_PER_LINE(WPL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Data memory: combinational read, store at the negedge of a store cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = fill(i);
        forever begin
            @(negedge clk);
            if (reset && bus.opcode_out == c_store) mem[bus.addr_out[9:2]] = bus.data_to_dmem;
        end
    end
    always_comb bus.data_from_dmem = mem[bus.addr_out[9:2]];

    // Responder: holds resp_ready low for rr_delay response cycles.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = bus.resp_valid && (vcnt >= rr_delay);
        end
    end

    // Monitor: pops predicted memory ops and responses as the engine shows them.
    initial begin
        op_t   e;
        resp_t r;
        vcnt     = 0;
        done_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.opcode_out != 7'd0) begin
                    if (op_q.size() == 0) begin
                        chk("unexpected_op", LB'(bus.opcode_out), LB'(0));
                    end else begin
                        e = op_q.pop_front();
                        chk("op_code", LB'(bus.opcode_out), LB'(e.op));
                        chk("op_addr", LB'(bus.addr_out), LB'(e.addr));
                        chk("op_data", LB'(bus.data_to_dmem), LB'(e.data));
                        chk("op_cycle", LB'(cyc), LB'(e.cyc));
                        chk("op_ready_low", LB'(bus.req_ready), LB'(0));
                    end
                end else begin
                    chk("idle_addr_zero", LB'(bus.addr_out), LB'(0));
                    chk("idle_data_zero", LB'(bus.data_to_dmem), LB'(0));
                end
                if (bus.resp_valid) begin
                    chk("resp_ready_low", LB'(bus.req_ready), LB'(0));
                    if (resp_q.size() == 0) begin
                        chk("unexpected_resp", LB'(bus.resp_valid), LB'(0));
                    end else begin
                        r = resp_q[0];
                        if (vcnt == 0) chk("resp_latency", LB'(cyc), LB'(r.e0 + WPL));
                        chk("resp_rdata", bus.resp_rdata, r.rdata);
                        if (bus.resp_ready) begin
                            void'(resp_q.pop_front());
                            done_cyc = cyc;
                            vcnt     = 0;
                        end else begin
                            vcnt++;
                        end
                    end
                end
            end
        end
    end

    // Issues one request and predicts its memory ops and response.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [LB-1:0] wd,
                          input bit keep, input int rdelay, output int e0);
        int            guard;
        int            idx;
        logic [31:0]   base;
        logic [31:0]   waddr;
        logic [LB-1:0] expd;
        @(posedge clk);
        #1;
        bus.req_valid     = 1'b1;
        bus.req_write     = wr;
        bus.req_line_addr = a;
        bus.req_wdata     = wd;
        rr_delay          = rdelay;
        guard             = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", LB'(0), LB'(1));
            bus.req_valid = 1'b0;
            e0 = 0;
            return;
        end
        e0   = cyc + 1;
        base = a & ~32'(WPL * 4 - 1);
        expd = last_rdata;
        for (int i = 0; i < WPL; i++) begin
            waddr = base + 32'(4 * i);
            idx   = int'(waddr[9:2]);
            if (wr) begin
                ref_mem[idx] = wd[32*i +: 32];
                op_q.push_back('{c_store, waddr, wd[32*i +: 32], e0 + i});
            end else begin
                expd[32*i +: 32] = ref_mem[idx];
                op_q.push_back('{c_load, waddr, 32'd0, e0 + i});
            end
        end
        last_rdata = expd;
        resp_q.push_back('{expd, e0});
        @(posedge clk);
        #1;
        bus.req_valid = keep;
    endtask

    initial begin
        logic [LB-1:0] wd;
        logic [31:0]   base;
        int            e0a;
        int            e0b;
        int            guard;
        checks = 0;
        errors = 0;
        rr_delay = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_line_addr = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = fill(i);
        last_rdata = '0;

        // Reset with random activity on the inputs.
        #2 reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.req_valid     = 1'($urandom_range(0, 1));
            bus.req_write     = 1'($urandom_range(0, 1));
            bus.req_line_addr = $urandom;
            bus.req_wdata     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("rst_opcode", LB'(bus.opcode_out), LB'(0));
            chk("rst_addr", LB'(bus.addr_out), LB'(0));
            chk("rst_data", LB'(bus.data_to_dmem), LB'(0));
            chk("rst_resp_valid", LB'(bus.resp_valid), LB'(0));
            chk("rst_rdata", bus.resp_rdata, LB'(0));
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", LB'(bus.req_ready), LB'(1));

        // Directed writeback, then readback of the same line.
        wd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_req(1'b1, 32'h0000_0014, wd, 1'b0, 0, e0a);
        do_req(1'b0, 32'h0000_0010, '0, 1'b0, 0, e0a);

        // Preload 0x40..0x4C and refill from an address inside that line.
        wd = {32'h44, 32'h33, 32'h22, 32'h11};
        do_req(1'b1, 32'h0000_0040, wd, 1'b0, 0, e0a);
        do_req(1'b0, 32'h0000_0048, '0, 1'b0, 0, e0a);

        // Backpressure on both a refill and a writeback acknowledge.
        do_req(1'b0, 32'h0000_0048, '0, 1'b0, 5, e0a);
        wd = {$urandom, $urandom, $urandom, $urandom};
        do_req(1'b1, 32'h0000_0100, wd, 1'b0, 5, e0a);

        // Reset after two store cycles of a writeback.
        @(posedge clk);
        #1;
        rr_delay          = 0;
        base              = 32'h0000_0200;
        wd                = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        bus.req_valid     = 1'b1;
        bus.req_write     = 1'b1;
        bus.req_line_addr = base;
        bus.req_wdata     = wd;
        guard             = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_accept", LB'(bus.req_ready), LB'(1));
        e0a = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            ref_mem[int'(base[9:2]) + i] = wd[32*i +: 32];
            op_q.push_back('{c_store, base + 32'(4 * i), wd[32*i +: 32], e0a + i});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_rdata = '0;
        #1;
        chk("abort_opcode", LB'(bus.opcode_out), LB'(0));
        chk("abort_addr", LB'(bus.addr_out), LB'(0));
        chk("abort_data", LB'(bus.data_to_dmem), LB'(0));
        chk("abort_resp_valid", LB'(bus.resp_valid), LB'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        do_req(1'b0, base, '0, 1'b0, 0, e0a);

        // Back-to-back: second request held valid across the first response.
        wd = {$urandom, $urandom, $urandom, $urandom};
        do_req(1'b1, 32'h0000_0300, wd, 1'b1, 0, e0a);
        do_req(1'b0, 32'h0000_0304, '0, 1'b0, 0, e0b);
        chk("b2b_accept_cycle", LB'(e0b), LB'(done_cyc + 2));

        // Randomized traffic.
        repeat (20) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            wd = {$urandom, $urandom, $urandom, $urandom};
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), wd,
                   1'b0, int'($urandom_range(0, 3)), e0a);
        end

        guard = 0;
        while ((op_q.size() != 0 || resp_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("op_queue_drained", LB'(op_q.size()), LB'(0));
        chk("resp_queue_drained", LB'(resp_q.size()), LB'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/line_mem_engine.md
# line_mem_engine

Multi-word transfer initiator that sits between the L2 cache controller and the word-wide data memory. It accepts one cache-line request (refill or writeback), sequences it into consecutive single-word load/store opcode cycles on the data-memory port, collects load data, and returns the complete line to L2 through a valid/ready response. It drives the opcode/address/data port that the data memory consumes.

## Interface
Parameters:
- WORDS_PER_LINE, 4, words per line; power of two, ≥2
- LINE_BITS, 32*WORDS_PER_LINE, derived width of a flattened line

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  L2 presents a line request
- req_ready  out  1  engine accepts request this cycle
- req_write  in  1  1 = writeback (stores), 0 = refill (loads)
- req_line_addr  in  32  byte address inside target line; low log2(WORDS_PER_LINE)+2 bits ignored
- req_wdata  in  LINE_BITS  writeback line; word i at bits [32i+31:32i]
- resp_valid  out  1  transfer complete
- resp_ready  in  1  L2 consumes response
- resp_rdata  out  LINE_BITS  refill line, same packing as req_wdata
- opcode_out  out  7  7'b0000011 load, 7'b0100011 store, 7'b0000000 idle
- addr_out  out  32  byte address of current word
- data_to_dmem  out  32  store data for current word
- data_from_dmem  in  32  combinational load data from data memory

## Operation
- States: IDLE, XFER, RESP.
- IDLE: req_ready=1, opcode_out=0, addr_out=0, data_to_dmem=0. On req_valid: latch req_write, aligned base (offset bits cleared), req_wdata; word counter=0; go to XFER.
- XFER: req_ready=0. opcode_out = store if latched write else load. addr_out = base + 4*cnt. data_to_dmem = word cnt of latched wdata for stores, 0 for loads. For loads, data_from_dmem is captured into resp_rdata word cnt at the posedge ending the cycle. cnt increments each cycle; at cnt==WORDS_PER_LINE-1 the closing edge moves to RESP.
- RESP: opcode_out=0, addr_out=0, data_to_dmem=0, resp_valid=1, resp_rdata stable. Hold until resp_ready=1, then go to IDLE. Writebacks also produce a response (acknowledge); resp_rdata keeps its previous contents.
- Word order: ascending address, word 0 first. Base is line-aligned, so a line never crosses an alignment boundary; address arithmetic is 32-bit unsigned.
- Counter width: log2(WORDS_PER_LINE) bits.

## Timing
- Reset (reset=0, asynchronous): state IDLE, cnt=0, latched data cleared, resp_rdata=0, resp_valid=0, req_ready=1 once the reset releases into IDLE, opcode_out/addr_out/data_to_dmem=0.
- Reset mid-XFER: stops immediately. No further opcode is issued. Words already stored remain in memory. No response is produced.
- Accept edge = E0. XFER occupies cycles E0..E0+WORDS_PER_LINE-1, one word per cycle. resp_valid is high from edge E0+WORDS_PER_LINE.
- Outputs are registered/state-decoded and stable for the full cycle. The memory stores at the following negedge, so store data and address hold through that negedge.
- Minimum request-to-request spacing: WORDS_PER_LINE+2 cycles (XFER, one RESP cycle, one IDLE cycle). req_valid is ignored outside IDLE, including in the cycle where resp_valid&resp_ready completes.
- resp_ready held low: the engine stays in RESP indefinitely with outputs unchanged.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0, req_ready=1 after release, no opcode issued.
- Writeback: req_write=1, addr 0x0000_0014, wdata words {0xA0,0xA1,0xA2,0xA3} → stores to 0x10,0x14,0x18,0x1C in four consecutive cycles with matching data. resp_valid at E0+4. Memory readback matches.
- Refill: preload memory 0x40..0x4C with 0x11,0x22,0x33,0x44; request addr 0x48, req_write=0 → four loads at 0x40..0x4C, resp_rdata={0x44,0x33,0x22,0x11} (MSW..LSW) at E0+4.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_rdata stable, opcode_out=0, req_ready=0. Response completes on the first resp_ready=1.
- Reset mid-writeback: assert reset after 2 store cycles → only words 0–1 written, outputs zero immediately, no resp_valid, next request runs normally.
- Back-to-back: req_valid held high across a response → second request accepted exactly one cycle after RESP exits, never during RESP.
